edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//  Fast-domain collector for level signals arriving from a slow clock domain. Each channel is
//  synchronised, edge-detected and latched as a pending event. A round-robin arbiter then
//  serialises pending events onto one valid/ready channel, so a single consumer can service
//  all slow-domain events. Sits at the slow->fast boundary, in front of the fast-domain event handler.
// PARAMETERS
//  N_CH         4   number of slow-domain input channels (2..16)
//  SYNC_STAGES  2   synchroniser flops per channel (2..4)
//  EDGE_SEL     0   0 = rising edges only, 1 = falling edges only, 2 = both edges
// PORTS
//  clk_fast    in   1               only clock; all logic is on its posedge
//  rst         in   1               synchronous, active-high reset
//  data_in     in   N_CH            async levels from slow domain (registered there)
//  evt_valid   out  1               event presented
//  evt_ready   in   1               consumer accepts event when evt_valid & evt_ready
//  evt_ch      out  $clog2(N_CH)    channel index of the presented event
//  evt_rise    out  1               1 = rising edge, 0 = falling edge
//  ovf         out  N_CH            sticky per-channel overflow (edge lost)
//  ovf_clr     in   N_CH            per-bit clear of ovf
// BEHAVIOUR
//  Clocking: one clock (clk_fast). Reset is synchronous and active-high (rst).
//  Reset values: evt_valid=0, evt_ch=0, evt_rise=0, ovf=0, pending=0, rr pointer=0, sync/history flops=0.
//  Warm-up: after rst deasserts, a counter runs for SYNC_STAGES+1 cycles. During this time edge
//   detection is masked, so a level already high at reset does not produce an event.
//  Sync: data_in[i] passes through SYNC_STAGES flops. s = last stage; h = s delayed by one cycle.
//   rise = s & ~h; fall = ~s & h. An edge is qualified by EDGE_SEL.
//  Latency: a level change on data_in is visible as evt_valid=1 after SYNC_STAGES+2 clk_fast
//   cycles, provided the channel wins arbitration and the output is free.
//  Pending: per channel, one pending bit plus one polarity bit. A qualified edge sets pending and
//   records the polarity.
//  Overflow: if an edge arrives while the channel is already pending and is not being granted in
//   the same cycle, set ovf[i]. The new edge is dropped and the stored polarity is kept.
//  Simultaneous grant and edge on the same channel: the set wins. Pending stays 1 with the new
//   polarity, and ovf is not set.
//  Output register load condition: (!evt_valid | evt_ready) and at least one pending bit.
//   On load, pick the first pending channel searching from ptr, ptr+1, ... mod N_CH.
//   Load evt_ch and evt_rise, clear that pending bit, and set ptr = granted+1 (wraps N_CH-1 -> 0).
//   If nothing is pending and the event is accepted, evt_valid goes to 0.
//  Handshake: evt_ch and evt_rise are stable while evt_valid & !evt_ready. evt_valid never drops
//   without acceptance. Back-to-back accepts are allowed, one event per cycle.
//  ovf clear: ovf_clr[i] clears ovf[i]. A set in the same cycle wins over the clear.
//  rst mid-operation: all pending events, the presented event and ovf are discarded, and warm-up restarts.
// STRUCTURE
//  Shared package: EDGE_RISE/EDGE_FALL/EDGE_BOTH constants for EDGE_SEL, and the clog2 width helper.
//  Sub-module sync_edge_det, one instance per channel. It contains the SYNC_STAGES synchroniser,
//   the history flop and the EDGE_SEL qualification, with outputs rise/fall.
//  The top level holds the warm-up counter, the pending/polarity/ovf arrays, the rr arbiter and the output register.
// TESTING (N_CH=4, SYNC_STAGES=2, EDGE_SEL=0 unless stated)
//  1 Hold data_in=4'b0010 through rst, then release -> no event, because warm-up masks the edge.
//  2 data_in[2] 0->1, evt_ready=1 -> evt_valid=1, evt_ch=2, evt_rise=1 at cycle 4; evt_valid=0 next cycle.
//  3 Rise channels 0,1,3 in the same cycle, evt_ready=1 -> evt_ch sequence 0,1,3 on consecutive cycles.
//    After that, a rise on 0 and 1 -> order 0,1 (ptr=0 after granting 3).
//  4 evt_ready=0 with ch1 presented; pulse data_in[1] twice -> evt_ch stays 1 and ovf[1]=1.
//    After acceptance, exactly one more ch1 event appears. ovf_clr[1] -> ovf[1]=0.
//  5 EDGE_SEL=2: data_in[0] 0->1->0 spaced 3 cycles, ready=1 -> two events: evt_rise=1, then evt_rise=0.
//  6 Assert rst while evt_valid=1 with 2 pending -> evt_valid=0 next cycle, no events replayed, ovf=0.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and helpers for the slow->fast edge event arbiter.
// EDGE_SEL encodings and a channel-index width helper.
package edge_event_arbiter_pkg;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   // Index width for n channels, never narrower than one bit
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event channel between the arbiter and the fast-domain handler.
interface edge_event_arbiter_if
   import edge_event_arbiter_pkg::*;
   #(parameter int N_CH = 4);

   localparam int CH_W = clog2w(N_CH);

   logic            evt_valid;
   logic            evt_ready;
   logic [CH_W-1:0] evt_ch;
   logic            evt_rise;

   modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
   modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);

endinterface

// File: rtl/edge_event_arbiter_sync_edge_det.sv
// Per-channel synchroniser, history flop and edge qualification.
module sync_edge_det
   import edge_event_arbiter_pkg::*;
   #(
      parameter int SYNC_STAGES = 2,
      parameter int EDGE_SEL    = EDGE_RISE
   )
   (
      input  logic clk_fast,
      input  logic rst,
      input  logic data_in,
      output logic rise,
      output logic fall
   );

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   s;

   always_ff @(posedge clk_fast) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Polarity filter folds to constants once EDGE_SEL is fixed
   assign rise = (EDGE_SEL != EDGE_FALL) & s & ~hist_q;
   assign fall = (EDGE_SEL != EDGE_RISE) & ~s & hist_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects synchronised edges from slow-domain levels as pending events and
// serialises them round-robin onto one valid/ready channel.
module edge_event_arbiter
   import edge_event_arbiter_pkg::*;
   #(
      parameter int N_CH        = 4,
      parameter int SYNC_STAGES = 2,
      parameter int EDGE_SEL    = EDGE_RISE
   )
   (
      input  logic                  clk_fast,
      input  logic                  rst,
      input  logic [N_CH-1:0]       data_in,
      edge_event_arbiter_if.master  evt,
      output logic [N_CH-1:0]       ovf,
      input  logic [N_CH-1:0]       ovf_clr
   );

   localparam int CH_W = clog2w(N_CH);
   localparam int WU_W = $clog2(SYNC_STAGES + 2);
   localparam logic [WU_W-1:0] WU_END = WU_W'(SYNC_STAGES + 1);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] edge_hit;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] pol;
   logic [N_CH-1:0] grant_vec;
   logic [WU_W-1:0] wu_cnt;
   logic            armed;
   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] gnt_idx;
   logic            found;
   logic            load;
   logic            valid_q;
   logic [CH_W-1:0] ch_q;
   logic            rise_q;
   int              idx;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sync_edge_det #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_SEL    (EDGE_SEL)
      ) u_det (
         .clk_fast (clk_fast),
         .rst      (rst),
         .data_in  (data_in[i]),
         .rise     (rise[i]),
         .fall     (fall[i])
      );
   end

   // Masks the synchroniser fill so levels already high at reset stay silent
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         wu_cnt <= '0;
      end else if (wu_cnt != WU_END) begin
         wu_cnt <= wu_cnt + 1'b1;
      end
   end

   assign armed    = (wu_cnt == WU_END);
   assign edge_hit = (rise | fall) & {N_CH{armed}};

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(ptr) + k) % N_CH;
         if (!found && pending[idx]) begin
            found   = 1'b1;
            gnt_idx = CH_W'(idx);
         end
      end
   end

   assign load = (!valid_q || evt.evt_ready) && found;

   always_comb begin
      grant_vec = '0;
      if (load) begin
         grant_vec[gnt_idx] = 1'b1;
      end
   end

   // A fresh edge beats a same-cycle grant; otherwise a second edge is dropped as overflow
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         pending <= '0;
         pol     <= '0;
         ovf     <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (edge_hit[i] && (!pending[i] || grant_vec[i])) begin
               pending[i] <= 1'b1;
               pol[i]     <= rise[i];
            end else if (grant_vec[i]) begin
               pending[i] <= 1'b0;
            end
            if (edge_hit[i] && pending[i] && !grant_vec[i]) begin
               ovf[i] <= 1'b1;
            end else if (ovf_clr[i]) begin
               ovf[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_fast) begin
      if (rst) begin
         valid_q <= 1'b0;
         ch_q    <= '0;
         rise_q  <= 1'b0;
         ptr     <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         ch_q    <= gnt_idx;
         rise_q  <= pol[gnt_idx];
         ptr     <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      end else if (evt.evt_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_ch    = ch_q;
   assign evt.evt_rise  = rise_q;

endmodule
